// File: rtl/instr_decode_stage_if.sv
// Handshake bundle between fetch, decode and the register-file/ALU stage.
// slave is the decode stage's view; master is the surrounding pipeline's.
interface instr_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [6:0]      out_funct7;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc,
    output out_opcode, out_rd, out_funct3,
    output out_rs1, out_rs2, out_funct7,
    output out_fmt, out_imm, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc,
    input  out_opcode, out_rd, out_funct3,
    input  out_rs1, out_rs2, out_funct7,
    input  out_fmt, out_imm, out_illegal
  );
endinterface

// File: rtl/instr_decode_stage.sv
// RV32I/RV64I decode stage: field split, format/immediate decode,
// two-entry skid buffer and saturating decode statistics.
module instr_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  instr_decode_stage_if.slave bus,
  output logic [CNT_W-1:0] dec_count,
  output logic [CNT_W-1:0] ill_count
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            ill;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } state_t;

  state_t state_q, state_d;
  ent_t   m_q, m_d;
  ent_t   k_q, k_d;
  ent_t   dec;
  logic [CNT_W-1:0] dec_q, ill_q;

  logic [31:0] ins;
  logic [6:0]  opc;
  logic [31:0] imm32;
  logic is_r, is_i, is_s, is_b, is_u, is_j;
  logic in_rdy, out_vld, acc, pop;

  assign ins  = bus.in_instr;
  assign opc  = ins[6:0];
  assign is_r = opc == 7'b0110011;
  assign is_i = opc == 7'b0010011 || opc == 7'b0000011 ||
                opc == 7'b1100111 || opc == 7'b1110011;
  assign is_s = opc == 7'b0100011;
  assign is_b = opc == 7'b1100011;
  assign is_u = opc == 7'b0110111 || opc == 7'b0010111;
  assign is_j = opc == 7'b1101111;

  always_comb begin
    dec.pc    = bus.in_pc;
    dec.instr = ins;
    dec.fmt   = 3'd7;
    dec.ill   = 1'b1;
    imm32     = '0;
    unique case (1'b1)
      is_r: begin
        dec.fmt = 3'd0;
        dec.ill = 1'b0;
      end
      is_i: begin
        dec.fmt = 3'd1;
        dec.ill = 1'b0;
        imm32   = {{20{ins[31]}}, ins[31:20]};
      end
      is_s: begin
        dec.fmt = 3'd2;
        dec.ill = 1'b0;
        imm32   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      is_b: begin
        dec.fmt = 3'd3;
        dec.ill = 1'b0;
        imm32   = {{19{ins[31]}}, ins[31], ins[7],
                   ins[30:25], ins[11:8], 1'b0};
      end
      is_u: begin
        dec.fmt = 3'd4;
        dec.ill = 1'b0;
        imm32   = {ins[31:12], 12'b0};
      end
      is_j: begin
        dec.fmt = 3'd5;
        dec.ill = 1'b0;
        imm32   = {{11{ins[31]}}, ins[31], ins[19:12],
                   ins[20], ins[30:21], 1'b0};
      end
      default: ;
    endcase
    // 32-bit immediate widened with instr[31] as the sign bit
    dec.imm = XLEN'($signed(imm32));
  end

  assign in_rdy  = state_q != FULL;
  assign out_vld = state_q != EMPTY;
  assign acc     = bus.in_valid & in_rdy;
  assign pop     = out_vld & bus.out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    k_d     = k_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            m_d     = dec;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (acc && pop) begin
            m_d = dec;
          end else if (acc) begin
            k_d     = dec;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            m_d     = k_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      m_q     <= '0;
      k_q     <= '0;
      dec_q   <= '0;
      ill_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      k_q     <= k_d;
      if (acc && !flush) begin
        if (dec_q != '1) dec_q <= dec_q + CNT_W'(1);
        if (dec.ill && ill_q != '1) ill_q <= ill_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready    = in_rdy;
  assign bus.out_valid   = out_vld;
  assign bus.out_pc      = m_q.pc;
  assign bus.out_opcode  = m_q.instr[6:0];
  assign bus.out_rd      = m_q.instr[11:7];
  assign bus.out_funct3  = m_q.instr[14:12];
  assign bus.out_rs1     = m_q.instr[19:15];
  assign bus.out_rs2     = m_q.instr[24:20];
  assign bus.out_funct7  = m_q.instr[31:25];
  assign bus.out_fmt     = m_q.fmt;
  assign bus.out_imm     = m_q.imm;
  assign bus.out_illegal = m_q.ill;
  assign dec_count       = dec_q;
  assign ill_count       = ill_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: XLEN=32/CNT_W=16 and XLEN=64/CNT_W=4
// instances share stimulus; a queue model checks both every cycle.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [63:0] pc = '0;
  logic        out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_decode_stage_if #(.XLEN(32)) if32 ();
  instr_decode_stage_if #(.XLEN(64)) if64 ();

  assign if32.in_valid  = in_valid;
  assign if32.in_instr  = instr;
  assign if32.in_pc     = pc[31:0];
  assign if32.out_ready = out_ready;
  assign if64.in_valid  = in_valid;
  assign if64.in_instr  = instr;
  assign if64.in_pc     = pc;
  assign if64.out_ready = out_ready;

  logic [15:0] dc32, ic32;
  logic [3:0]  dc64, ic64;

  instr_decode_stage #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if32),
    .dec_count(dc32), .ill_count(ic32)
  );

  instr_decode_stage #(.XLEN(64), .CNT_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if64),
    .dec_count(dc64), .ill_count(ic64)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] p, input logic [31:0] i);
    exp_t e;
    e.pc = p;
    e.instr = i;
    e.ill = 1'b0;
    e.imm = '0;
    e.fmt = 3'd7;
    case (i[6:0])
      7'h33: e.fmt = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73: begin
        e.fmt = 3'd1;
        e.imm = 64'($signed(i[31:20]));
      end
      7'h23: begin
        e.fmt = 3'd2;
        e.imm = 64'($signed({i[31:25], i[11:7]}));
      end
      7'h63: begin
        e.fmt = 3'd3;
        e.imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      end
      7'h37, 7'h17: begin
        e.fmt = 3'd4;
        e.imm = 64'($signed({i[31:12], 12'b0}));
      end
      7'h6F: begin
        e.fmt = 3'd5;
        e.imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] flds(input logic [31:0] i);
    return {i[6:0], i[11:7], i[14:12], i[19:15], i[24:20], i[31:25]};
  endfunction

  exp_t q[$];
  exp_t shown;
  exp_t ent;
  exp_t e;
  int   mdec = 0;
  int   mill = 0;
  bit   started = 0;
  bit   m_rdy, m_vld;

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      mdec = 0;
      mill = 0;
      shown = '0;
      started = 1;
    end else if (flush) begin
      q.delete();
    end else begin
      m_rdy = q.size() < 2;
      m_vld = q.size() > 0;
      if (m_vld && out_ready) void'(q.pop_front());
      if (in_valid && m_rdy) begin
        ent = mk(pc, instr);
        q.push_back(ent);
        mdec++;
        if (ent.ill) mill++;
      end
      if (q.size() > 0) shown = q[0];
    end
  end

  always @(negedge clk) begin
    if (started) begin
      e = (q.size() > 0) ? q[0] : shown;
      chk("m_vld32", 64'(if32.out_valid), 64'(q.size() > 0));
      chk("m_rdy32", 64'(if32.in_ready), 64'(q.size() < 2));
      chk("m_vld64", 64'(if64.out_valid), 64'(q.size() > 0));
      chk("m_rdy64", 64'(if64.in_ready), 64'(q.size() < 2));
      chk("m_pc32", 64'(if32.out_pc), 64'(e.pc[31:0]));
      chk("m_pc64", if64.out_pc, e.pc);
      chk("m_fld32", 64'({if32.out_opcode, if32.out_rd, if32.out_funct3,
          if32.out_rs1, if32.out_rs2, if32.out_funct7}), 64'(flds(e.instr)));
      chk("m_fld64", 64'({if64.out_opcode, if64.out_rd, if64.out_funct3,
          if64.out_rs1, if64.out_rs2, if64.out_funct7}), 64'(flds(e.instr)));
      chk("m_dec32", 64'({if32.out_fmt, if32.out_illegal, if32.out_imm}),
          64'({e.fmt, e.ill, e.imm[31:0]}));
      chk("m_fmt64", 64'({if64.out_fmt, if64.out_illegal}),
          64'({e.fmt, e.ill}));
      chk("m_imm64", if64.out_imm, e.imm);
      chk("m_dc32", 64'(dc32), 64'((mdec > 65535) ? 65535 : mdec));
      chk("m_ic32", 64'(ic32), 64'((mill > 65535) ? 65535 : mill));
      chk("m_dc64", 64'(dc64), 64'((mdec > 15) ? 15 : mdec));
      chk("m_ic64", 64'(ic64), 64'((mill > 15) ? 15 : mill));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] imm_ins [4] = '{32'hFE112E23, 32'hFE000EE3,
                               32'h800000B7, 32'hFF9FF0EF};
  logic [2:0]  imm_fmt [4] = '{3'd2, 3'd3, 3'd4, 3'd5};
  logic [63:0] imm_val [4] = '{64'hFFFF_FFFF_FFFF_FFFC,
                               64'hFFFF_FFFF_FFFF_FFFC,
                               64'hFFFF_FFFF_8000_0000,
                               64'hFFFF_FFFF_FFFF_FFF8};

  initial begin
    step();
    step();
    chk("rst_vld", 64'(if32.out_valid), 64'd0);
    chk("rst_rdy", 64'(if32.in_ready), 64'd1);
    chk("rst_cnt", 64'(dc32), 64'd0);
    rst_n = 1'b1;
    step();

    in_valid = 1'b1;
    instr = 32'hFFF10093;
    pc = 64'h100;
    step();
    in_valid = 1'b0;
    chk("addi_vld", 64'(if32.out_valid), 64'd1);
    chk("addi_rd", 64'(if32.out_rd), 64'd1);
    chk("addi_rs1", 64'(if32.out_rs1), 64'd2);
    chk("addi_fmt", 64'(if32.out_fmt), 64'd1);
    chk("addi_imm", 64'(if32.out_imm), 64'hFFFF_FFFF);
    chk("addi_ill", 64'(if32.out_illegal), 64'd0);
    chk("addi_cnt", 64'(dc32), 64'd1);
    step();

    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      instr = imm_ins[k];
      pc = 64'h8000_0000_0000_1000 + 64'(k * 4);
      step();
      chk("imm_fmt", 64'(if64.out_fmt), 64'(imm_fmt[k]));
      chk("imm_val", if64.out_imm, imm_val[k]);
    end
    in_valid = 1'b0;
    step();

    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = 32'h00A00093;
    pc = 64'h200;
    step();
    instr = 32'h00B00113;
    pc = 64'h204;
    step();
    chk("bp_full", 64'(if32.in_ready), 64'd0);
    instr = 32'h00C00193;
    pc = 64'h208;
    step();
    step();
    chk("bp_hold", 64'(if32.out_pc), 64'h200);
    out_ready = 1'b1;
    step();
    chk("bp_pop1", 64'(if32.out_pc), 64'h204);
    chk("bp_rdy", 64'(if32.in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_pop2", 64'(if32.out_pc), 64'h208);
    step();
    chk("bp_empty", 64'(if32.out_valid), 64'd0);

    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      instr = {12'(k * 37), 5'd1, 3'b000, 5'(k), 7'b0010011};
      pc = 64'h300 + 64'(k * 4);
      step();
      chk("st_rdy", 64'(if32.in_ready), 64'd1);
      chk("st_pc", 64'(if32.out_pc), 64'h300 + 64'(k * 4));
    end
    in_valid = 1'b0;
    step();

    in_valid = 1'b1;
    instr = 32'h0000007F;
    pc = 64'h400;
    step();
    chk("il_fmt", 64'(if64.out_fmt), 64'd7);
    chk("il_imm", if64.out_imm, 64'd0);
    chk("il_bit", 64'(if64.out_illegal), 64'd1);
    chk("il_cnt", 64'(ic64), 64'd1);
    for (int k = 1; k < 20; k++) begin
      pc = 64'h400 + 64'(k * 4);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("sat_dec", 64'(dc64), 64'd15);
    chk("sat_ill", 64'(ic64), 64'd15);
    chk("ill32", 64'(ic32), 64'd20);

    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = 32'h00100073;
    pc = 64'h500;
    step();
    instr = 32'h00000033;
    pc = 64'h504;
    step();
    flush = 1'b1;
    instr = 32'h123450B7;
    pc = 64'h508;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_vld", 64'(if32.out_valid), 64'd0);
    chk("fl_rdy", 64'(if32.in_ready), 64'd1);
    chk("fl_cnt", 64'(dc32), 64'd40);
    out_ready = 1'b1;
    step();
    step();
    step();

    out_ready = 1'b0;
    in_valid = 1'b1;
    instr = 32'hFFF10093;
    pc = 64'hFFFF_0000_0000_0600;
    step();
    in_valid = 1'b0;
    chk("rb_vld", 64'(if64.out_valid), 64'd1);
    rst_n = 1'b0;
    step();
    chk("rr_vld", 64'(if64.out_valid), 64'd0);
    chk("rr_rdy", 64'(if64.in_ready), 64'd1);
    chk("rr_fmt", 64'(if64.out_fmt), 64'd0);
    chk("rr_imm", if64.out_imm, 64'd0);
    chk("rr_ill", 64'(if64.out_illegal), 64'd0);
    chk("rr_pc", if64.out_pc, 64'd0);
    chk("rr_dc", 64'(dc32), 64'd0);
    chk("rr_ic", 64'(ic32), 64'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
